force_accumulator: RTL and testbench

FORCE_ACCUMULATOR -- requirements
Module: force_accumulator

---
 rtl/force_accumulator.sv | 184 ++++++++++++++++++
 tb/tb_force_accumulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/force_accumulator.sv
// Accumulates the signed 2-D force on one body from every other entry of a body table.
// Three-stage pipeline: |delta| and direction, scaled magnitude, saturating accumulation.
module force_accumulator #(
  parameter int unsigned N_BODIES = 4,
  parameter int unsigned XW       = 7,
  parameter int unsigned YW       = 6,
  parameter int unsigned INV_W    = 20,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned G_SHIFT  = 3,
  parameter int unsigned ACC_W    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(N_BODIES)-1:0]     obj_idx,
  input  logic [XW-1:0]                   obj_x,
  input  logic [YW-1:0]                   obj_y,
  output logic [$clog2(N_BODIES)-1:0]     rd_addr,
  input  logic [XW-1:0]                   rd_x,
  input  logic [YW-1:0]                   rd_y,
  output logic [XW-1:0]                   dx_abs,
  output logic [YW-1:0]                   dy_abs,
  input  logic [INV_W-1:0]                inv_cube,
  output logic                            busy,
  output logic                            done,
  output logic signed [ACC_W-1:0]         x_force,
  output logic signed [ACC_W-1:0]         y_force,
  output logic [$clog2(N_BODIES):0]       pair_cnt,
  output logic                            sat
);

  localparam int unsigned AW  = $clog2(N_BODIES);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned FW  = G_SHIFT + FRAC;
  localparam int unsigned SH  = INV_W - FRAC - G_SHIFT;
  localparam int unsigned SW  = ACC_W + 1;
  localparam int unsigned PXW = XW + INV_W;
  localparam int unsigned PYW = YW + INV_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       drain_cnt_q;
  logic [AW-1:0]    obj_idx_q;
  logic [XW-1:0]    obj_x_q;
  logic [YW-1:0]    obj_y_q;
  logic             s0_valid_q;
  logic [AW-1:0]    s0_idx_q;
  logic             s1_valid_q, s1_sx_q, s1_sy_q;
  logic             s2_valid_q, s2_sx_q, s2_sy_q;
  logic [FW-1:0]    s2_fx_q, s2_fy_q;
  logic [ACC_W-1:0] acc_x_q, acc_y_q;
  logic [CW-1:0]    cnt_q;
  logic             sat_q;

  logic             accept, last_addr;
  logic [XW-1:0]    dx_n;
  logic [YW-1:0]    dy_n;
  logic [PXW-1:0]   prod_x;
  logic [PYW-1:0]   prod_y;
  logic             clip_x, clip_y;
  logic [ACC_W-1:0] add_x, add_y, acc_x_n, acc_y_n;
  logic [CW-1:0]    cnt_n;
  logic             sat_n;

  // Returns {clipped, result}; one add of a narrower magnitude needs only one guard bit.
  function automatic logic [SW-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                            input logic [FW-1:0] mag, input logic pos);
    logic [SW-1:0] a, m, s;
    a = {acc[ACC_W-1], acc};
    m = SW'(mag);
    s = pos ? a + m : a - m;
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}} : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  assign accept    = start && (state_q == StIdle || state_q == StDone);
  assign last_addr = (rd_addr == AW'(N_BODIES - 1));
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_addr) state_d = StDrain;
      StDrain: if (drain_cnt_q == 2'd2) state_d = StDone;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dx_n   = (obj_x_q > rd_x) ? obj_x_q - rd_x : rd_x - obj_x_q;
    dy_n   = (obj_y_q > rd_y) ? obj_y_q - rd_y : rd_y - obj_y_q;
    prod_x = PXW'(dx_abs) * PXW'(inv_cube);
    prod_y = PYW'(dy_abs) * PYW'(inv_cube);
    {clip_x, add_x} = sat_add(acc_x_q, s2_fx_q, s2_sx_q);
    {clip_y, add_y} = sat_add(acc_y_q, s2_fy_q, s2_sy_q);
    acc_x_n = s2_valid_q ? add_x : acc_x_q;
    acc_y_n = s2_valid_q ? add_y : acc_y_q;
    cnt_n   = cnt_q + CW'(s2_valid_q);
    sat_n   = sat_q | (s2_valid_q & (clip_x | clip_y));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
      rd_addr     <= '0;
      obj_idx_q   <= '0;
      obj_x_q     <= '0;
      obj_y_q     <= '0;
      s0_valid_q  <= 1'b0;
      s0_idx_q    <= '0;
      dx_abs      <= '0;
      dy_abs      <= '0;
      s1_valid_q  <= 1'b0;
      s1_sx_q     <= 1'b0;
      s1_sy_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sx_q     <= 1'b0;
      s2_sy_q     <= 1'b0;
      s2_fx_q     <= '0;
      s2_fy_q     <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      x_force     <= '0;
      y_force     <= '0;
      pair_cnt    <= '0;
      sat         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_addr     <= '0;
        drain_cnt_q <= '0;
        obj_idx_q   <= obj_idx;
        obj_x_q     <= obj_x;
        obj_y_q     <= obj_y;
        acc_x_q     <= '0;
        acc_y_q     <= '0;
        cnt_q       <= '0;
        sat_q       <= 1'b0;
      end else begin
        if (state_q == StRun && !last_addr) rd_addr <= rd_addr + AW'(1);
        if (state_q == StDrain) drain_cnt_q <= drain_cnt_q + 2'd1;
        acc_x_q <= acc_x_n;
        acc_y_q <= acc_y_n;
        cnt_q   <= cnt_n;
        sat_q   <= sat_n;
      end
      // Table data lags rd_addr by one cycle, so the index travels alongside it.
      s0_valid_q <= (state_q == StRun);
      s0_idx_q   <= rd_addr;
      if (s0_valid_q) begin
        dx_abs  <= dx_n;
        dy_abs  <= dy_n;
        s1_sx_q <= (obj_x_q > rd_x);
        s1_sy_q <= (obj_y_q > rd_y);
      end
      s1_valid_q <= s0_valid_q && (s0_idx_q != obj_idx_q) && (dx_n != '0 || dy_n != '0);
      s2_valid_q <= s1_valid_q;
      s2_sx_q    <= s1_sx_q;
      s2_sy_q    <= s1_sy_q;
      s2_fx_q    <= FW'(prod_x >> SH);
      s2_fy_q    <= FW'(prod_y >> SH);
      // Results include the final pair, which is accumulated on this same edge.
      if (state_q == StDrain && state_d == StDone) begin
        x_force  <= acc_x_n;
        y_force  <= acc_y_n;
        pair_cnt <= cnt_n;
        sat      <= sat_n;
      end
    end
  end

endmodule

// File: tb/tb_force_accumulator.sv
// Randomized and directed bench for force_accumulator against a plain-arithmetic force model.
module tb_force_accumulator;

  localparam int N     = 4;
  localparam int XW    = 7;
  localparam int YW    = 6;
  localparam int INV_W = 20;
  localparam int FRAC  = 8;
  localparam int GS    = 3;
  localparam int ACC_W = 12;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [1:0]           obj_idx = '0;
  logic [XW-1:0]        obj_x = '0;
  logic [YW-1:0]        obj_y = '0;
  logic [1:0]           rd_addr;
  logic [XW-1:0]        rd_x = '0;
  logic [YW-1:0]        rd_y = '0;
  logic [XW-1:0]        dx_abs;
  logic [YW-1:0]        dy_abs;
  logic [INV_W-1:0]     inv_cube;
  logic                 busy, done, sat;
  logic signed [ACC_W-1:0] x_force, y_force;
  logic [2:0]           pair_cnt;

  logic [XW-1:0] tbl_x [N];
  logic [YW-1:0] tbl_y [N];

  int total = 0;
  int bad   = 0;

  force_accumulator #(
    .N_BODIES(N), .XW(XW), .YW(YW), .INV_W(INV_W), .FRAC(FRAC), .G_SHIFT(GS), .ACC_W(ACC_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .obj_idx(obj_idx), .obj_x(obj_x), .obj_y(obj_y),
    .rd_addr(rd_addr), .rd_x(rd_x), .rd_y(rd_y), .dx_abs(dx_abs), .dy_abs(dy_abs),
    .inv_cube(inv_cube), .busy(busy), .done(done), .x_force(x_force), .y_force(y_force),
    .pair_cnt(pair_cnt), .sat(sat)
  );

  always #5 clk = ~clk;

  // Synchronous body table: data follows the address by one cycle.
  always @(posedge clk) begin
    rd_x <= tbl_x[rd_addr];
    rd_y <= tbl_y[rd_addr];
  end

  // Stand-in for the inverse-cube unit: full scale at unit distance, a hash elsewhere.
  function automatic logic [INV_W-1:0] inv_of(input int dx, input int dy);
    if (dx + dy == 1) return 20'hFFFFF;
    return INV_W'((dx * 131 + dy * 7919 + 1) * 40503);
  endfunction

  always_comb inv_cube = inv_of(int'(dx_abs), int'(dy_abs));

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int oi, input int ox, input int oy,
                       output int ex, output int ey, output int ec, output int es);
    longint ax, ay, mx, my, hi, lo;
    int dx, dy;
    hi = (64'sd1 <<< (ACC_W - 1)) - 1;
    lo = -(64'sd1 <<< (ACC_W - 1));
    ax = 0; ay = 0; ec = 0; es = 0;
    for (int j = 0; j < N; j++) begin
      dx = (ox > int'(tbl_x[j])) ? ox - int'(tbl_x[j]) : int'(tbl_x[j]) - ox;
      dy = (oy > int'(tbl_y[j])) ? oy - int'(tbl_y[j]) : int'(tbl_y[j]) - oy;
      if (j == oi || (dx == 0 && dy == 0)) continue;
      mx = ((longint'(dx) * longint'(inv_of(dx, dy))) >> (INV_W - FRAC - GS)) % 2048;
      my = ((longint'(dy) * longint'(inv_of(dx, dy))) >> (INV_W - FRAC - GS)) % 2048;
      ax += (ox > int'(tbl_x[j])) ? mx : -mx;
      ay += (oy > int'(tbl_y[j])) ? my : -my;
      if (ax > hi) begin ax = hi; es = 1; end
      if (ax < lo) begin ax = lo; es = 1; end
      if (ay > hi) begin ay = hi; es = 1; end
      if (ay < lo) begin ay = lo; es = 1; end
      ec++;
    end
    ex = int'(ax); ey = int'(ay);
  endtask

  // Called between edges; returns #1 after the edge that shows done (lat = edges from accept).
  task automatic run(input int oi, input int ox, input int oy, input int restart_at,
                     output int lat, output longint x_early);
    obj_idx = 2'(oi); obj_x = XW'(ox); obj_y = YW'(oy);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    x_early = longint'(x_force);
    for (int c = 1; c <= 40; c++) begin
      if (c == restart_at) begin
        start = 1'b1; obj_x = ~obj_x; obj_idx = ~obj_idx;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic run_check(input string tag, input int oi, input int ox, input int oy);
    int lat, ex, ey, ec, es;
    longint xe;
    model(oi, ox, oy, ex, ey, ec, es);
    run(oi, ox, oy, 0, lat, xe);
    check({tag, "_lat"}, lat, N + 3);
    check({tag, "_x"}, longint'(x_force), ex);
    check({tag, "_y"}, longint'(y_force), ey);
    check({tag, "_cnt"}, pair_cnt, ec);
    check({tag, "_sat"}, sat, es);
  endtask

  task automatic set_tbl(input int x0, y0, x1, y1, x2, y2, x3, y3);
    tbl_x[0] = XW'(x0); tbl_y[0] = YW'(y0); tbl_x[1] = XW'(x1); tbl_y[1] = YW'(y1);
    tbl_x[2] = XW'(x2); tbl_y[2] = YW'(y2); tbl_x[3] = XW'(x3); tbl_y[3] = YW'(y3);
  endtask

  initial begin
    int lat, nd;
    longint xe;
    set_tbl(10, 10, 11, 10, 10, 10, 10, 10);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_dx", dx_abs, 0);
    check("rst_dy", dy_abs, 0);
    check("rst_x", longint'(x_force), 0);
    check("rst_cnt", pair_cnt, 0);
    check("rst_sat", sat, 0);

    // Single unit-distance neighbour on the +x side pulls toward -x.
    run(0, 10, 10, 0, lat, xe);
    check("d1_lat", lat, 7);
    check("d1_x", longint'(x_force), -2047);
    check("d1_y", longint'(y_force), 0);
    check("d1_cnt", pair_cnt, 1);
    check("d1_sat", sat, 0);
    check("d1_busy", busy, 0);

    set_tbl(12, 10, 11, 10, 12, 10, 12, 10);
    run_check("d2", 0, 12, 10);
    check("d2_xv", longint'(x_force), 2047);

    set_tbl(10, 10, 9, 10, 9, 10, 9, 10);
    run_check("satp", 0, 10, 10);
    check("satp_xv", longint'(x_force), 2047);
    check("satp_sv", sat, 1);
    set_tbl(10, 10, 11, 10, 11, 10, 11, 10);
    run_check("satn", 0, 10, 10);
    check("satn_xv", longint'(x_force), -2048);

    // Start during RUN must be ignored; exactly one done.
    set_tbl(10, 10, 11, 10, 10, 10, 10, 10);
    run(0, 10, 10, 2, lat, xe);
    check("ign_lat", lat, 7);
    check("ign_x", longint'(x_force), -2047);
    check("ign_cnt", pair_cnt, 1);
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("ign_extra_done", nd, 0);

    // Back-to-back: start in the DONE cycle; prior results held meanwhile.
    run(0, 10, 10, 0, lat, xe);
    set_tbl(12, 10, 11, 10, 12, 10, 12, 10);
    run(0, 12, 10, 0, lat, xe);
    check("b2b_hold", xe, -2047);
    check("b2b_lat", lat, 7);
    check("b2b_x", longint'(x_force), 2047);

    // Reset on the third RUN cycle aborts the run.
    obj_idx = 2'd0; obj_x = 7'd12; obj_y = 6'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    check("abort_done", nd, 0);
    check("abort_x", longint'(x_force), 0);
    check("abort_cnt", pair_cnt, 0);
    check("abort_busy", busy, 0);
    run_check("post_rst", 0, 12, 10);

    for (int it = 0; it < 25; it++) begin
      int oi, ox, oy;
      for (int j = 0; j < N; j++) begin
        tbl_x[j] = XW'($urandom_range(0, 127));
        tbl_y[j] = YW'($urandom_range(0, 63));
      end
      oi = int'($urandom_range(0, N - 1));
      ox = int'($urandom_range(0, 127));
      oy = int'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) begin
        tbl_x[(oi + 1) % N] = XW'(ox);
        tbl_y[(oi + 1) % N] = YW'(oy);
      end
      if ($urandom_range(0, 3) == 0) begin
        tbl_x[(oi + 2) % N] = XW'(ox + 1);
        tbl_y[(oi + 2) % N] = YW'(oy);
      end
      run_check("rnd", oi, ox, oy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
